// File: rtl/mem_dump_unit.sv
// mem_dump_unit: dumps data memory over the UART once the CPU halts.
//
// On i_start (sampled in IDLE) it walks addresses 0..N_WORDS-1. It holds the
// read strobe for two cycles so the combinational memory read can settle, then
// captures the word and sends it as two bytes, MSB first, waiting for the UART
// to acknowledge each byte. Every output is registered.
//
// Ports:
//   i_clock    system clock, rising edge
//   i_reset    asynchronous active-low reset
//   i_start    dump request, ignored unless idle
//   o_Rd       read strobe to datamemory
//   o_Addr     read address to datamemory
//   i_Data     read data from datamemory
//   o_tx_data  byte to uart_tx
//   o_tx_start one-cycle send request to uart_tx
//   i_tx_done  one-cycle acknowledge from uart_tx
//   o_busy     high whenever not idle
//   o_done     one-cycle pulse after the last byte is acknowledged
//
// Optional: define DUMP_CHECKSUM_EN to append one byte holding the XOR of
// every byte sent in the dump.

module mem_dump_unit #(
  parameter int unsigned NBITS_O = 11,
  parameter int unsigned NBITS_D = 16,
  parameter int unsigned NBITS_B = 8,
  parameter int unsigned N_WORDS = 512
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  output logic               o_Rd,
  output logic [NBITS_O-1:0] o_Addr,
  input  logic [NBITS_D-1:0] i_Data,
  output logic [NBITS_B-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [NBITS_O-1:0] LastAddr = NBITS_O'(N_WORDS - 1);

  typedef enum logic [3:0] {
    StIdle,
    StRead,
    StLatch,
    StSendHi,
    StWaitHi,
    StSendLo,
    StWaitLo,
    StNext,
`ifdef DUMP_CHECKSUM_EN
    StSendCk,
    StWaitCk,
`endif
    StFinish
  } state_e;

  state_e             state_q, state_d;
  logic [NBITS_O-1:0] cnt_q, cnt_d;
  // Only the low byte is kept: the high byte goes straight to o_tx_data.
  logic [NBITS_B-1:0] lo_byte_q, lo_byte_d;
  logic [NBITS_B-1:0] tx_data_q, tx_data_d;
  logic               rd_q, rd_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
  logic [NBITS_B-1:0] ck_q, ck_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lo_byte_d = lo_byte_q;
    tx_data_d = tx_data_q;
`ifdef DUMP_CHECKSUM_EN
    ck_d      = ck_q;
`endif
    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StRead;
          cnt_d   = '0;
`ifdef DUMP_CHECKSUM_EN
          ck_d    = '0;
`endif
        end
      end
      StRead:   state_d = StLatch;
      StLatch: begin
        lo_byte_d = i_Data[NBITS_B-1:0];
        tx_data_d = i_Data[NBITS_D-1:NBITS_B];
`ifdef DUMP_CHECKSUM_EN
        ck_d      = ck_q ^ i_Data[NBITS_D-1:NBITS_B];
`endif
        state_d   = StSendHi;
      end
      StSendHi: state_d = StWaitHi;
      StWaitHi: begin
        if (i_tx_done) begin
          tx_data_d = lo_byte_q;
`ifdef DUMP_CHECKSUM_EN
          ck_d      = ck_q ^ lo_byte_q;
`endif
          state_d   = StSendLo;
        end
      end
      StSendLo: state_d = StWaitLo;
      StWaitLo: begin
        if (i_tx_done) state_d = StNext;
      end
      StNext: begin
        if (cnt_q == LastAddr) begin
`ifdef DUMP_CHECKSUM_EN
          tx_data_d = ck_q;
          state_d   = StSendCk;
`else
          state_d   = StFinish;
`endif
        end else begin
          cnt_d   = cnt_q + NBITS_O'(1);
          state_d = StRead;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      StSendCk: state_d = StWaitCk;
      StWaitCk: begin
        if (i_tx_done) state_d = StFinish;
      end
`endif
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state.
  always_comb begin
    rd_d       = (state_d == StRead) || (state_d == StLatch);
    tx_start_d = (state_d == StSendHi) || (state_d == StSendLo)
`ifdef DUMP_CHECKSUM_EN
                 || (state_d == StSendCk)
`endif
                 ;
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StFinish);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lo_byte_q  <= '0;
      tx_data_q  <= '0;
      rd_q       <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      ck_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lo_byte_q  <= lo_byte_d;
      tx_data_q  <= tx_data_d;
      rd_q       <= rd_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DUMP_CHECKSUM_EN
      ck_q       <= ck_d;
`endif
    end
  end

  assign o_Rd       = rd_q;
  assign o_Addr     = cnt_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit with a 10-word memory holding memory[k] = k.
module tb_mem_dump_unit;

  localparam int NW = 10;
`ifdef DUMP_CHECKSUM_EN
  localparam int NB      = 2 * NW + 1;
  localparam int DoneLat = 0;
`else
  localparam int NB      = 2 * NW;
  localparam int DoneLat = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tx_done = 1'b0;
  logic        rd;
  logic [10:0] addr;
  logic [15:0] data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  int tx_count = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  assign data = 16'(addr);

  mem_dump_unit #(
    .NBITS_O(11),
    .NBITS_D(16),
    .NBITS_B(8),
    .N_WORDS(NW)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst_n),
    .i_start   (start),
    .o_Rd      (rd),
    .o_Addr    (addr),
    .i_Data    (data),
    .o_tx_data (tx_data),
    .o_tx_start(tx_start),
    .i_tx_done (tx_done),
    .o_busy    (busy),
    .o_done    (done)
  );

  always @(negedge clk) begin
    if (tx_start === 1'b1) tx_count++;
    if (done === 1'b1) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int b);
    if (b >= 2 * NW) return 8'h01;
    return (b % 2 == 0) ? 8'h00 : 8'(b / 2);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},       32'(rd),       32'd0);
    check({tag, "_addr"},     32'(addr),     32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
  endtask

  task automatic wait_tx(output int cyc);
    cyc = 0;
    while (tx_start !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("tx_start_seen", 32'(tx_start), 32'd1);
  endtask

  task automatic ack();
    repeat (4) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic run_dump(input bit extras);
    int cyc;
    int tx0;
    int d0;
    int tx_before;
    bit held;
    bit rd_low;
    d0  = done_count;
    tx0 = tx_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_read_rd",   32'(rd),       32'd1);
    check("lat_read_busy", 32'(busy),     32'd1);
    check("lat_read_txs",  32'(tx_start), 32'd0);
    check("lat_read_addr", 32'(addr),     32'd0);
    tick();
    check("lat_latch_rd",  32'(rd),       32'd1);
    check("lat_latch_txs", 32'(tx_start), 32'd0);
    // A stray acknowledge while latching must not skip ahead.
    if (extras) tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("lat_send_hi", 32'(tx_start), 32'd1);
    for (int b = 0; b < NB; b++) begin
      if (b > 0) begin
        wait_tx(cyc);
        if (b == 1) check("hi_to_lo_lat", 32'(cyc), 32'd0);
        if (b == 2) check("next_word_lat", 32'(cyc), 32'd3);
      end
      check($sformatf("byte%0d", b), 32'(tx_data), 32'(exp_byte(b)));
      if (b % 2 == 0 && b < 2 * NW) check($sformatf("addr%0d", b / 2), 32'(addr), 32'(b / 2));
      if (extras && b == 3) begin
        tx_before = tx_count;
        held = 1'b1;
        rd_low = 1'b1;
        tick();
        check("tx_start_pulse", 32'(tx_start), 32'd0);
        repeat (200) begin
          tick();
          if (tx_data !== 8'h01) held = 1'b0;
          if (rd !== 1'b0) rd_low = 1'b0;
          if (tx_start !== 1'b0) held = 1'b0;
        end
        check("stall_held", 32'(held), 32'd1);
        check("stall_rd_low", 32'(rd_low), 32'd1);
        check("stall_no_tx", 32'(tx_count - tx_before), 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
      end else if (extras && b == 5) begin
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
      end else begin
        ack();
      end
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_lat", 32'(cyc), 32'(DoneLat));
    check("done_busy", 32'(busy), 32'd1);
    tick();
    check("done_pulse_end", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("done_count", 32'(done_count - d0), 32'd1);
    check("byte_count", 32'(tx_count - tx0), 32'(NB));
  endtask

  initial begin
    int cyc;
    // Reset held with start asserted.
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    start = 1'b0;
    rst_n = 1'b1;
    repeat (20) tick();
    check("idle_busy_20", 32'(busy), 32'd0);
    check("idle_no_tx", 32'(tx_count), 32'd0);

    // Acknowledge in IDLE does nothing.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (5) tick();
    check("idle_done_busy", 32'(busy), 32'd0);
    check("idle_done_rd", 32'(rd), 32'd0);
    check("idle_done_tx", 32'(tx_count), 32'd0);

    // Full dump with stall and ignored events.
    run_dump(1'b1);

    // Abort mid-dump in WAIT_HI of word 4.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b <= 8; b++) begin
      wait_tx(cyc);
      if (b < 8) ack();
    end
    check("abort_byte8", 32'(tx_data), 32'h00);
    check("abort_addr4", 32'(addr), 32'd4);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    tick();
    #3;
    rst_n = 1'b1;
    repeat (3) tick();
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_txs", 32'(tx_start), 32'd0);

    // Clean restart from address 0.
    run_dump(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
